pipe_stage_hs: RTL and testbench

//  Generic parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying one packed payload.

---
 rtl/pipe_stage_hs_pkg.sv | 24 ++
 rtl/pipe_stage_hs_reg.sv | 26 ++
 rtl/pipe_stage_hs.sv | 130 +++++++++++++
 tb/tb_pipe_stage_hs.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_hs_pkg.sv
// Shared definitions for the handshaked pipeline stage register.
// Holds the state encoding (which doubles as the occupancy count), the
// per-stage payload widths, and a helper mapping state to occupancy.
package pipe_stage_hs_pkg;

    // The encoding equals the number of live entries held by the stage.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_BUSY  = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

    // Widths of the stage bundles that instantiate this block.
    localparam int AluopWidth = 5;
    localparam int WdtTypeCnt = 4;
    localparam int SigOpWidth = 6;
    localparam int InstWidth  = 32;
    localparam int IdExWidth  = AluopWidth + WdtTypeCnt + SigOpWidth + 4*64 + InstWidth;

    function automatic logic [1:0] occ_of(input pipe_state_e st);
        return logic'(st == PIPE_FULL) ? 2'd2 : {1'b0, st == PIPE_BUSY};
    endfunction

endpackage

// File: rtl/pipe_stage_hs_reg.sv
// Payload register with write enable and asynchronous reset to RESET_VAL.
// Ports:
//   i_clk  clock            i_rst  async reset, active high
//   i_wen  load enable      i_d    next value
//   o_q    registered value
module pipe_stage_hs_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)      r_q <= RESET_VAL;
        else if (i_wen) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous
// flush and an optional 2-entry skid buffer.
//
// state      | meaning
// PIPE_EMPTY | no live entry, out_valid low
// PIPE_BUSY  | head holds one live entry
// PIPE_FULL  | head and skid both live, upstream stalled (SKID=1 only)
//
// Ports:
//   i_clk, i_rst     clock, async active-high reset
//   i_flush          drop all held entries and any word accepted this cycle
//   i_in_valid       upstream valid        o_in_ready   stage accepts i_in_data
//   i_in_data        upstream payload
//   o_out_valid      o_out_data is live    i_out_ready  downstream consumes
//   o_out_data       head payload          o_occupancy  live entries 0..2
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [1:0]       o_occupancy
);

    pipe_state_e      r_state;
    pipe_state_e      w_state_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_head_wen;
    logic             w_skid_wen;
    logic             w_head_from_skid;
    logic [WIDTH-1:0] w_head_d;
    logic [WIDTH-1:0] w_head_q;
    logic [WIDTH-1:0] w_skid_q;

    assign o_out_valid = (r_state != PIPE_EMPTY);
    assign o_occupancy = occ_of(r_state);
    assign o_out_data  = w_head_q;
    assign w_in_xfer   = i_in_valid & o_in_ready;
    assign w_out_xfer  = o_out_valid & i_out_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= PIPE_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // With SKID=0 the ready rule keeps BUSY from ever seeing an input
    // transfer without an output transfer, so FULL is unreachable there.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_wen       = 1'b0;
        w_skid_wen       = 1'b0;
        w_head_from_skid = 1'b0;
        case (r_state)
            PIPE_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = PIPE_BUSY;
                    w_head_wen  = 1'b1;
                end
            end
            PIPE_BUSY: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_head_wen = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = PIPE_FULL;
                    w_skid_wen  = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = PIPE_EMPTY;
                end
            end
            PIPE_FULL: begin
                if (w_out_xfer) begin
                    w_state_nxt      = PIPE_BUSY;
                    w_head_wen       = 1'b1;
                    w_head_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = PIPE_EMPTY;
        endcase
        // Loads are suppressed on flush so a discarded word never reaches
        // the output, even as stale don't-care data.
        if (i_flush) begin
            w_state_nxt = PIPE_EMPTY;
            w_head_wen  = 1'b0;
            w_skid_wen  = 1'b0;
        end
    end

    generate
        if (SKID) begin : g_skid_ready
            logic r_in_ready;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) r_in_ready <= 1'b1;
                else       r_in_ready <= (w_state_nxt != PIPE_FULL);
            end
            assign o_in_ready = r_in_ready;
        end else begin : g_comb_ready
            assign o_in_ready = ~o_out_valid | i_out_ready;
        end
    endgenerate

    assign w_head_d = w_head_from_skid ? w_skid_q : i_in_data;

    pipe_stage_hs_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_head (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_wen (w_head_wen),
        .i_d   (w_head_d),
        .o_q   (w_head_q)
    );

    pipe_stage_hs_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_wen (w_skid_wen),
        .i_d   (i_in_data),
        .o_q   (w_skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: one SKID=1 and one SKID=0 instance, directed
// vectors followed by a queue-scoreboarded random run.
module tb_pipe_stage_hs;

    localparam int               W  = 16;
    localparam logic [W-1:0]     RV = 16'hBEEF;

    logic         clk = 1'b0;
    logic         rst;
    logic         s1_flush, s1_iv, s1_ir, s1_ov, s1_or;
    logic [W-1:0] s1_id, s1_od;
    logic [1:0]   s1_occ;
    logic         s0_flush, s0_iv, s0_ir, s0_ov, s0_or;
    logic [W-1:0] s0_id, s0_od;
    logic [1:0]   s0_occ;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b1)) u_s1 (
        .i_clk(clk), .i_rst(rst), .i_flush(s1_flush),
        .i_in_valid(s1_iv), .o_in_ready(s1_ir), .i_in_data(s1_id),
        .o_out_valid(s1_ov), .i_out_ready(s1_or), .o_out_data(s1_od),
        .o_occupancy(s1_occ)
    );

    pipe_stage_hs #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b0)) u_s0 (
        .i_clk(clk), .i_rst(rst), .i_flush(s0_flush),
        .i_in_valid(s0_iv), .o_in_ready(s0_ir), .i_in_data(s0_id),
        .o_out_valid(s0_ov), .i_out_ready(s0_or), .o_out_data(s0_od),
        .o_occupancy(s0_occ)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_s1(input string tag, input logic ov, input logic [1:0] occ,
                          input logic ir, input logic [W-1:0] od);
        check_val({tag, ".ov"},  32'(s1_ov),  32'(ov));
        check_val({tag, ".occ"}, 32'(s1_occ), 32'(occ));
        check_val({tag, ".ir"},  32'(s1_ir),  32'(ir));
        check_val({tag, ".od"},  32'(s1_od),  32'(od));
    endtask

    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];

    initial begin
        rst = 1'b1;
        s1_flush = 0; s1_iv = 0; s1_id = '0; s1_or = 0;
        s0_flush = 0; s0_iv = 0; s0_id = '0; s0_or = 0;
        #12;
        chk_s1("reset", 1'b0, 2'd0, 1'b1, RV);
        check_val("s0_reset.od", 32'(s0_od), 32'(RV));
        tick();
        rst = 1'b0;

        // Streaming, out_ready held high
        s1_or = 1; s1_iv = 1; s1_id = 16'h11;
        check_val("stream.ir0", 32'(s1_ir), 32'd1);
        tick(); chk_s1("stream1", 1'b1, 2'd1, 1'b1, 16'h11);
        s1_id = 16'h22;
        tick(); chk_s1("stream2", 1'b1, 2'd1, 1'b1, 16'h22);
        s1_id = 16'h33;
        tick(); chk_s1("stream3", 1'b1, 2'd1, 1'b1, 16'h33);
        s1_iv = 0;
        tick(); chk_s1("stream_drain", 1'b0, 2'd0, 1'b1, 16'h33);

        // Backpressure into the skid buffer
        s1_or = 0; s1_iv = 1; s1_id = 16'h0A;
        tick(); chk_s1("bp_a", 1'b1, 2'd1, 1'b1, 16'h0A);
        s1_id = 16'h0B;
        tick(); chk_s1("bp_b", 1'b1, 2'd2, 1'b0, 16'h0A);
        s1_id = 16'h0C;
        tick(); chk_s1("bp_c_held", 1'b1, 2'd2, 1'b0, 16'h0A);
        s1_or = 1;
        tick(); chk_s1("bp_pop_b", 1'b1, 2'd1, 1'b1, 16'h0B);
        tick(); chk_s1("bp_pop_c", 1'b1, 2'd1, 1'b1, 16'h0C);
        s1_iv = 0;
        tick(); chk_s1("bp_empty", 1'b0, 2'd0, 1'b1, 16'h0C);

        // Flush while FULL, 0xD presented
        s1_or = 0; s1_iv = 1; s1_id = 16'h01;
        tick(); s1_id = 16'h02;
        tick(); chk_s1("fl_full", 1'b1, 2'd2, 1'b0, 16'h01);
        s1_flush = 1; s1_id = 16'h0D;
        tick(); chk_s1("fl_full_kill", 1'b0, 2'd0, 1'b1, 16'h01);
        // Flush while BUSY with in_ready=1: accepted 0xE is dropped
        s1_flush = 0; s1_id = 16'h05;
        tick(); chk_s1("fl_busy_pre", 1'b1, 2'd1, 1'b1, 16'h05);
        s1_flush = 1; s1_id = 16'h0E;
        tick(); chk_s1("fl_busy_kill", 1'b0, 2'd0, 1'b1, 16'h05);
        s1_flush = 0; s1_iv = 0;
        tick(); chk_s1("idle_hold", 1'b0, 2'd0, 1'b1, 16'h05);

        // Reset mid-stream with occupancy 2, seen in the same cycle
        s1_iv = 1; s1_id = 16'h06;
        tick(); s1_id = 16'h16;
        tick(); chk_s1("rst_pre", 1'b1, 2'd2, 1'b0, 16'h06);
        rst = 1; #1;
        chk_s1("rst_mid", 1'b0, 2'd0, 1'b1, RV);
        rst = 0; s1_id = 16'h07;
        tick(); chk_s1("rst_after", 1'b1, 2'd1, 1'b1, 16'h07);

        // Flush and reset together: reset wins
        s1_iv = 0; s1_flush = 1; rst = 1; #1;
        chk_s1("rst_flush", 1'b0, 2'd0, 1'b1, RV);
        rst = 0; s1_flush = 0;
        tick();

        // SKID=0: combinational in_ready
        s0_or = 0; s0_iv = 1; s0_id = 16'h21; #1;
        check_val("s0.ir_empty", 32'(s0_ir), 32'd1);
        tick();
        check_val("s0.od1", 32'(s0_od), 32'h21);
        check_val("s0.ir_stall", 32'(s0_ir), 32'd0);
        check_val("s0.occ1", 32'(s0_occ), 32'd1);
        s0_or = 1; s0_id = 16'h22; #1;
        check_val("s0.ir_comb", 32'(s0_ir), 32'd1);
        tick();
        check_val("s0.od2", 32'(s0_od), 32'h22);
        s0_iv = 0;
        tick();
        check_val("s0.occ0", 32'(s0_occ), 32'd0);
        check_val("s0.ov0", 32'(s0_ov), 32'd0);

        // Random run against queue scoreboards
        rst = 1; #1; rst = 0;
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s1_iv    = 1'($urandom_range(0, 1));
            s1_or    = 1'($urandom_range(0, 1));
            s1_id    = W'($urandom);
            s1_flush = ($urandom_range(0, 99) < 5);
            s0_iv    = 1'($urandom_range(0, 1));
            s0_or    = 1'($urandom_range(0, 1));
            s0_id    = W'($urandom);
            s0_flush = 1'b0;
            #1;
            check_val("r1.occ", 32'(s1_occ), 32'(q1.size()));
            check_val("r1.ir",  32'(s1_ir),  32'(q1.size() != 2));
            if (s1_ov && s1_or && q1.size() > 0)
                check_val("r1.data", 32'(s1_od), 32'(q1.pop_front()));
            if (s1_flush)              q1.delete();
            else if (s1_iv && s1_ir)   q1.push_back(s1_id);

            check_val("r0.occ", 32'(s0_occ), 32'(q0.size()));
            check_val("r0.ir",  32'(s0_ir),  32'((q0.size() == 0) || s0_or));
            if (s0_ov && s0_or && q0.size() > 0)
                check_val("r0.data", 32'(s0_od), 32'(q0.pop_front()));
            if (s0_iv && s0_ir)        q0.push_back(s0_id);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
